core_mdu: RTL and testbench
===========================

Name: core_mdu

Overview:
- Iterative RV64M multiply/divide unit in the EX stage; initiator side of the hazard unit's mbusy/mdone stall handshake.
- Accepts an M-extension operation from EX and holds the pipeline via o_mdu_busy until the result is ready.
- Pulses o_mdu_done with the registered 64-bit result so the hazard unit releases the stall.
- Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants (MULW/DIVW/DIVUW/REMW/REMUW).

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- i_mdu_clk  in  1  core clock
- i_mdu_rst  in  1  asynchronous, active-high reset
- i_mdu_start  in  1  valid, unflushed M-op present in EX
- i_mdu_funct3  in  3  RV M funct3 (000 MUL … 111 REMU)
- i_mdu_word  in  1  W variant (OP-32 opcode)
- i_mdu_src_a  in  64  rs1 operand, after forwarding
- i_mdu_src_b  in  64  rs2 operand, after forwarding
- i_mdu_stall  in  1  EX held by another source (dcache, icache, uart, load-use)
- i_mdu_flush  in  1  EX flush (pcsrc or csr flush)
- o_mdu_busy  out  1  to hazard unit mbusy
- o_mdu_done  out  1  to hazard unit mdone
- o_mdu_result  out  64  result to the EX result mux

Behaviour:
- Reset: state=IDLE, o_mdu_done=0, o_mdu_result=0, all internal registers 0. o_mdu_busy follows i_mdu_start while in IDLE.
- FSM states: IDLE, CALC, FIX, DONE.
- o_mdu_busy = i_mdu_start in IDLE; 1 in CALC, FIX and DONE. It is combinational in IDLE so the pipeline stalls in the same cycle the op enters EX.
- o_mdu_done = 1 only in DONE. busy&&done releases the stall (mstall = busy&&!done).
- IDLE→CALC on start:
  - Latch funct3 and word.
  - Take absolute values of signed operands: MULH and DIV/REM both signed; MULHSU rs1 only; W ops use the sign-extended low 32 bits.
  - Record the result sign.
  - Load iteration counter N = 64 (32 if word).
- IDLE→DONE on start when a divide special case applies (result registered, done in cycle 1 after the start edge):
  - Divisor zero: quotient = all ones; remainder = dividend. Both are 32-bit-extended for W.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- CALC, one bit per cycle:
  - Multiply: radix-2 shift-add into a 128-bit accumulator.
  - Divide: restoring; the shift-subtract produces one quotient bit.
  - Counter decrements; at 0 → FIX.
- FIX:
  - Two's-complement negate if the recorded sign requires it.
    - Multiply: the 128-bit product.
    - Div: the quotient.
    - Rem: the remainder (takes the dividend's sign).
  - Select the result: MUL → low 64; MULH* → high 64; DIV*/REM* → quotient/remainder.
  - W ops: sign-extend bit 31 of the low word to 64, including DIVUW/REMUW.
  - Register into o_mdu_result → DONE.
- Latency: start in cycle 0; done in cycle N+2 (66 for 64-bit ops, 34 for W ops).
- DONE:
  - i_mdu_stall=0 → IDLE. The instruction leaves EX at this edge; start in the next cycle is a new op.
  - i_mdu_stall=1 → remain in DONE, holding the result and done=1. No restart while the same op is held.
- i_mdu_flush in any state → IDLE next edge, done=0; the result register is unchanged. Flush has priority over start and stall.
- Reset mid-operation → IDLE immediately (async); no done is produced.
- Result register changes only on the FIX→DONE and special-case edges.

Decomposition:
- Package core_mdu_pkg:
  - mdu_state_e (IDLE, CALC, FIX, DONE).
  - mdu_op_e funct3 encodings (MUL…REMU).
  - Constants MDU_ITER_D=64 and MDU_ITER_W=32.
- Sub-module core_mdu_divider holds the iterative restoring divide datapath: remainder/quotient shift registers and step enable.
- The multiply accumulator, sign handling and FSM stay in core_mdu.

Test Plan:
- MUL a=7, b=-3 → busy=1 from cycle 0; done=1 only in cycle 66; result 0xFFFF_FFFF_FFFF_FFEB; busy=0 in cycle 67 with start=0.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MULHSU a=-1, b=2 → result 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-7, b=2 → quotient 0xFFFF_FFFF_FFFF_FFFD; REM same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW a=0x0000_0001_8000_0000, b=-1 → done in cycle 1; result 0xFFFF_FFFF_8000_0000. DIVU b=0 → 0xFFFF_FFFF_FFFF_FFFF in cycle 1; REMU b=0 → a.
- REMUW a=0xFFFF_FFFF, b=1 → result 0, done in cycle 34. DIVUW a=0xFFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- i_mdu_stall=1 for 3 cycles during DONE → done and result held for 4 cycles, no restart. i_mdu_flush in CALC cycle 10 → IDLE next cycle, done never asserts. Async reset in CALC → busy=0 and done=0 immediately.

Source files
------------

// File: rtl/core_mdu_pkg.sv
// core_mdu_pkg: shared types and constants for the iterative RV64M multiply/divide unit.
// Ports: none (package). Provides FSM state enum, funct3 op enum, iteration counts
// and a 32->64 sign-extension helper used for the W variants.
package core_mdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    localparam int MDU_ITER_D = 64;
    localparam int MDU_ITER_W = 32;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/core_mdu_divider.sv
// core_mdu_divider: restoring divide datapath, one quotient bit per i_step cycle.
// Ports: i_clk/i_rst (async active-high), i_load captures dividend/divisor and clears
// the remainder, i_step runs one shift-subtract; o_quotient/o_remainder are the raw magnitudes.
module core_mdu_divider #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // The dividend shifts out of the top of r_quo into the partial remainder while
    // quotient bits shift in at the bottom. The shifted remainder can need XLEN+1 bits,
    // but when it is >= divisor the difference is always < divisor, so XLEN bits suffice.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/core_mdu.sv
// core_mdu: iterative RV64M multiply/divide unit; holds EX via o_mdu_busy and pulses o_mdu_done.
// Ports: i_mdu_clk, i_mdu_rst (async active-high), i_mdu_start/funct3/word/src_a/src_b from EX,
// i_mdu_stall/i_mdu_flush pipeline control; o_mdu_busy, o_mdu_done, o_mdu_result to hazard unit / EX mux.
module core_mdu
    import core_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_mdu_clk,
    input  logic            i_mdu_rst,
    input  logic            i_mdu_start,
    input  logic [2:0]      i_mdu_funct3,
    input  logic            i_mdu_word,
    input  logic [XLEN-1:0] i_mdu_src_a,
    input  logic [XLEN-1:0] i_mdu_src_b,
    input  logic            i_mdu_stall,
    input  logic            i_mdu_flush,
    output logic            o_mdu_busy,
    output logic            o_mdu_done,
    output logic [XLEN-1:0] o_mdu_result
);

    mdu_state_e        r_state, w_next;
    mdu_op_e           r_op;
    logic              r_word;
    logic              r_neg;
    logic [6:0]        r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    mdu_op_e           w_op;
    logic              w_is_div, w_is_rem, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
    logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min;
    logic              w_div_zero, w_ovf, w_special, w_accept;
    logic [XLEN-1:0]   w_spec_raw, w_spec_res;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix, w_fix_raw, w_fix_res;

    // ---------------- operand preparation (IDLE, straight from EX) ----------------
    assign w_op     = mdu_op_e'(i_mdu_funct3);
    assign w_is_div = i_mdu_funct3[2];
    assign w_is_rem = i_mdu_funct3[2] & i_mdu_funct3[1];
    assign w_a_sgn  = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_b_sgn  = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);

    assign w_a_ext = i_mdu_word ? (w_a_sgn ? sext32(i_mdu_src_a[31:0]) : {32'b0, i_mdu_src_a[31:0]})
                                : i_mdu_src_a;
    assign w_b_ext = i_mdu_word ? (w_b_sgn ? sext32(i_mdu_src_b[31:0]) : {32'b0, i_mdu_src_b[31:0]})
                                : i_mdu_src_b;
    assign w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
    assign w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
    assign w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;
    // Remainder follows the dividend's sign; quotient and product follow the XOR.
    assign w_neg   = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);

    // Divide special cases resolve without iterating.
    assign w_min      = i_mdu_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_div_zero = w_is_div && (w_b_ext == '0);
    assign w_ovf      = w_is_div && !i_mdu_funct3[0] && (w_a_ext == w_min) && (&w_b_ext);
    assign w_special  = w_div_zero || w_ovf;
    assign w_spec_raw = w_div_zero ? (w_is_rem ? w_a_ext : '1)
                                   : (w_is_rem ? '0 : w_a_ext);
    assign w_spec_res = i_mdu_word ? sext32(w_spec_raw[31:0]) : w_spec_raw;

    assign w_accept = (r_state == IDLE) && i_mdu_start && !i_mdu_flush;

    // ---------------- datapaths ----------------
    // Radix-2 shift-add: multiplier sits in the low half and is consumed LSB-first.
    assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

    core_mdu_divider #(.XLEN(XLEN)) u_div (
        .i_clk       (i_mdu_clk),
        .i_rst       (i_mdu_rst),
        .i_load      (w_accept),
        .i_step      ((r_state == CALC) && r_op[2]),
        // W ops pre-shift the 32-bit dividend so only 32 steps are needed.
        .i_dividend  (i_mdu_word ? {w_a_abs[31:0], 32'b0} : w_a_abs),
        .i_divisor   (w_b_abs),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_quo_fix = r_neg ? -w_quo : w_quo;
    assign w_rem_fix = r_neg ? -w_rem : w_rem;

    always_comb begin
        w_fix_raw = '0;
        if (r_op[2]) begin
            w_fix_raw = r_op[1] ? w_rem_fix : w_quo_fix;
        end else if (r_word) begin
            // After 32 steps the low product word has shifted into acc[63:32].
            w_fix_raw = {32'b0, r_acc[63:32]};
        end else if (r_op == OP_MUL) begin
            w_fix_raw = w_prod[XLEN-1:0];
        end else begin
            w_fix_raw = w_prod[2*XLEN-1:XLEN];
        end
    end
    assign w_fix_res = r_word ? sext32(w_fix_raw[31:0]) : w_fix_raw;

    // ---------------- FSM ----------------
    always_comb begin
        w_next     = r_state;
        o_mdu_busy = 1'b1;
        o_mdu_done = 1'b0;
        case (r_state)
            IDLE: begin
                o_mdu_busy = i_mdu_start;
                if (w_accept) w_next = w_special ? DONE : CALC;
            end
            CALC: if (r_cnt == 7'd1) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: begin
                o_mdu_done = 1'b1;
                if (!i_mdu_stall) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (i_mdu_flush) w_next = IDLE;
    end

    always_ff @(posedge i_mdu_clk or posedge i_mdu_rst) begin
        if (i_mdu_rst) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_word   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= w_op;
                r_word  <= i_mdu_word;
                r_neg   <= w_neg;
                r_cnt   <= i_mdu_word ? 7'(MDU_ITER_W) : 7'(MDU_ITER_D);
                r_mcand <= w_a_abs;
                r_acc   <= {{XLEN{1'b0}}, w_b_abs};
                if (w_special) r_result <= w_spec_res;
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt - 7'd1;
                if (!r_op[2]) r_acc <= {w_sum, r_acc[XLEN-1:1]};
            end else if ((r_state == FIX) && !i_mdu_flush) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign o_mdu_result = r_result;

endmodule

// File: tb/tb_core_mdu.sv
module tb_core_mdu;
    import core_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        word = 1'b0;
    logic [63:0] src_a = '0;
    logic [63:0] src_b = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [63:0] result;

    int nchk = 0;
    int nerr = 0;

    core_mdu dut (
        .i_mdu_clk    (clk),
        .i_mdu_rst    (rst),
        .i_mdu_start  (start),
        .i_mdu_funct3 (funct3),
        .i_mdu_word   (word),
        .i_mdu_src_a  (src_a),
        .i_mdu_src_b  (src_b),
        .i_mdu_stall  (stall),
        .i_mdu_flush  (flush),
        .o_mdu_busy   (busy),
        .o_mdu_done   (done),
        .o_mdu_result (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op in cycle 0, drops start afterwards, and checks latency, result
    // and that the unit is idle in the cycle after done.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic wd,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat);
        int  c;
        bit  seen;
        c    = 0;
        seen = 0;
        tick();
        funct3 = f3; word = wd; src_a = a; src_b = b; start = 1'b1;
        #1;
        nchk++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL %s cycle0 busy/done got %b/%b want 1/0", nm, busy, done);
        end
        while (!seen && c < 100) begin
            tick();
            c++;
            start = 1'b0;
            if (done === 1'b1) seen = 1;
        end
        nchk++;
        if (c !== lat) begin
            nerr++;
            $display("FAIL %s latency got %0d want %0d", nm, c, lat);
        end
        nchk++;
        if (result !== exp) begin
            nerr++;
            $display("FAIL %s result got %h want %h", nm, result, exp);
        end
        tick();
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL %s after-done busy/done got %b/%b want 0/0", nm, busy, done);
        end
    endtask

    task automatic test_reset();
        #2;
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            nerr++;
            $display("FAIL reset busy/done/result got %b/%b/%h want 0/0/0", busy, done, result);
        end
        start = 1'b1;
        #1;
        nchk++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL reset_busy_follows_start got %b want 1", busy);
        end
        start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op("mul",    3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu",  3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("mulw",   3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    endtask

    task automatic test_div();
        run_op("div",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem",  3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        run_op("divw", 3'b100, 1'b1, 64'h5555_5555_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    endtask

    task automatic test_special();
        run_op("divw_ovf",  3'b100, 1'b1, 64'h0000_0001_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divu_zero", 3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_zero", 3'b111, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1);
    endtask

    task automatic test_word();
        run_op("remuw", 3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 34);
        run_op("divuw", 3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    endtask

    // start stays high the whole time, as a held instruction would keep it.
    task automatic test_stall();
        int c;
        c = 0;
        tick();
        funct3 = 3'b101; word = 1'b1; src_a = 64'd100; src_b = 64'd7; start = 1'b1;
        while (done !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        nchk++;
        if (c !== 34) begin
            nerr++;
            $display("FAIL stall_latency got %0d want 34", c);
        end
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nchk++;
            if (done !== 1'b1 || busy !== 1'b1 || result !== 64'd14) begin
                nerr++;
                $display("FAIL stall_hold%0d done/busy/result got %b/%b/%h want 1/1/e", k, done, busy, result);
            end
            if (k == 3) begin
                stall = 1'b0;
                start = 1'b0;
            end
        end
        tick();
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL stall_release busy/done got %b/%b want 0/0", busy, done);
        end
    endtask

    task automatic test_flush();
        bit seen;
        seen = 0;
        tick();
        funct3 = 3'b100; word = 1'b0; src_a = 64'd1000; src_b = 64'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL flush_idle busy/done got %b/%b want 0/0", busy, done);
        end
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        nchk++;
        if (seen) begin
            nerr++;
            $display("FAIL flush_no_done got done=1 want never");
        end
        nchk++;
        if (result !== 64'd14) begin
            nerr++;
            $display("FAIL flush_result_kept got %h want e", result);
        end
    endtask

    task automatic test_async_reset();
        tick();
        funct3 = 3'b000; word = 1'b0; src_a = 64'd5; src_b = 64'd9; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        nchk++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL areset_pre busy got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            nerr++;
            $display("FAIL areset busy/done/result got %b/%b/%h want 0/0/0", busy, done, result);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) begin
                nchk++;
                nerr++;
                $display("FAIL areset_quiet busy/done got %b/%b want 0/0", busy, done);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
